spdif_tx_ctrl: RTL and testbench

//  Sequencer/feeder for the SPDIF transmitter. Buffers 32-bit stereo samples {R[31:16],L[15:0]}

---
 rtl/spdif_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_spdif_tx_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spdif_tx_ctrl.sv
// spdif_tx_ctrl: SPDIF transmitter feeder with sample FIFO, bit-rate NCO, priming and block-aligned rate switching.
// Define SPDIF_TX_CTRL_HOLD_ON_UNDERRUN_EN to repeat the last sample on underrun instead of muting.
module spdif_tx_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PRIME_LEVEL = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         rate_sel_i,
    input  logic                         s_valid_i,
    input  logic [31:0]                  s_data_i,
    output logic                         s_ready_o,
    output logic                         spdif_rst_o,
    output logic                         spdif_bit_en_o,
    output logic [31:0]                  spdif_sample_o,
    input  logic                         spdif_req_i,
    output logic                         rate_o,
    output logic                         running_o,
    output logic                         underrun_o,
    output logic [15:0]                  underrun_cnt_o,
    input  logic                         clr_stat_i,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LW     = AW + 1;
    localparam logic [31:0] INC_48 = 32'd6_144_000;
    localparam logic [31:0] INC_44 = 32'd5_644_800;
    localparam logic [31:0] CLK_W  = 32'(CLK_HZ);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   sample_q, sample_d, acc_q, acc_d, sum;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    frame_q, frame_d;
    logic          bit_en_q, bit_en_d, rate_q, rate_d, pend_q, pend_d, under_q, under_d;
    logic          push, pop, run;

    assign s_ready_o      = (state_q != IDLE) && (level_q < LW'(FIFO_DEPTH));
    assign spdif_rst_o    = state_q != RUN;
    assign running_o      = state_q == RUN;
    assign spdif_bit_en_o = bit_en_q;
    assign spdif_sample_o = sample_q;
    assign rate_o         = rate_q;
    assign underrun_o     = under_q;
    assign underrun_cnt_o = cnt_q;
    assign fifo_level_o   = level_q;

    // Next-state: sequencing, FIFO pointers, NCO, rate hand-over and underrun statistics
    always_comb begin
        run      = (state_q == RUN) && enable_i;
        push     = s_valid_i && s_ready_o;
        pop      = 1'b0;
        under_d  = 1'b0;
        state_d  = state_q;
        frame_d  = frame_q;
        rate_d   = (state_q == RUN) ? rate_q : rate_sel_i;
        pend_d   = rate_sel_i;
        sample_d = sample_q;
        sum      = acc_q + (rate_q ? INC_44 : INC_48);
        bit_en_d = run && (sum >= CLK_W);
        acc_d    = !run ? '0 : bit_en_d ? sum - CLK_W : sum;
        if (!enable_i) begin
            state_d  = IDLE;
            frame_d  = '0;
            sample_d = '0;
        end else if (state_q == IDLE) begin
            state_d = PRIME;
        end else if (state_q == PRIME) begin
            if (level_q >= LW'(PRIME_LEVEL)) begin
                state_d = RUN;
                pop     = 1'b1;
            end
        end else if (spdif_req_i) begin
            pop     = level_q != '0;
            under_d = level_q == '0;
            frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
            if (frame_q == 8'd191) rate_d = pend_q;
        end
        if (pop) sample_d = mem_q[rd_q];
`ifdef SPDIF_TX_CTRL_HOLD_ON_UNDERRUN_EN
        if (under_d) sample_d = sample_q;
`else
        if (under_d) sample_d = '0;
`endif
        wr_d    = enable_i ? wr_q + AW'(push) : '0;
        rd_d    = enable_i ? rd_q + AW'(pop) : '0;
        level_d = enable_i ? level_q + LW'(push) - LW'(pop) : '0;
        cnt_d   = clr_stat_i ? '0 : (under_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // State and control registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            sample_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            bit_en_q <= 1'b0;
            rate_q   <= 1'b0;
            pend_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            sample_q <= sample_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            bit_en_q <= bit_en_d;
            rate_q   <= rate_d;
            pend_q   <= pend_d;
            under_q  <= under_d;
        end
    end

    // Sample storage; contents are only read behind a non-zero level so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= s_data_i;
    end
endmodule

// File: tb/tb_spdif_tx_ctrl.sv
// tb_spdif_tx_ctrl: vector table plus sample scoreboard for spdif_tx_ctrl.
module tb_spdif_tx_ctrl;
`ifdef SPDIF_TX_CTRL_HOLD_ON_UNDERRUN_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk_i = 1'b0, rst_i = 1'b1, enable_i = 1'b0, rate_sel_i = 1'b0;
    logic        s_valid_i = 1'b0, spdif_req_i = 1'b0, clr_stat_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        s_ready_o, spdif_rst_o, spdif_bit_en_o, rate_o, running_o, underrun_o;
    logic [31:0] spdif_sample_o;
    logic [15:0] underrun_cnt_o;
    logic [2:0]  fifo_level_o;

    spdif_tx_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .rate_sel_i(rate_sel_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .spdif_rst_o(spdif_rst_o), .spdif_bit_en_o(spdif_bit_en_o), .spdif_sample_o(spdif_sample_o),
        .spdif_req_i(spdif_req_i), .rate_o(rate_o), .running_o(running_o), .underrun_o(underrun_o),
        .underrun_cnt_o(underrun_cnt_o), .clr_stat_i(clr_stat_i), .fifo_level_o(fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic [2:0]  lvl;
        logic        und;
        logic [15:0] cnt;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] mdl [$];
    logic [31:0] sb [$];
    logic [31:0] last_smp;
    int          n_vec = 0, n_bad = 0, nreq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        logic        acc;
        logic [31:0] e;
        s_valid_i   = v;
        s_data_i    = d;
        spdif_req_i = r;
        acc = v & s_ready_o;
        if (r) begin
            if (mdl.size() == 0) sb.push_back(HOLD ? last_smp : 32'h0);
            else sb.push_back(mdl.pop_front());
            nreq++;
        end
        if (acc) mdl.push_back(d);
        cyc();
        s_valid_i   = 1'b0;
        spdif_req_i = 1'b0;
        if (r) begin
            e = sb.pop_front();
            chk("sample", spdif_sample_o, e);
            last_smp = e;
        end
    endtask

    task automatic count_pulses(input int ncyc, output int pulses, output int adj);
        logic prev = 1'b0;
        pulses = 0;
        adj    = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            if (spdif_bit_en_o) pulses++;
            if (spdif_bit_en_o && prev) adj++;
            prev = spdif_bit_en_o;
        end
    endtask

    initial begin
        int p, a;
        tbl[0] = '{1'b1, 32'hA0A0_0001, 1'b0, 3'd2, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 32'h0,         1'b1, 3'd1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 32'hB0B0_0002, 1'b1, 3'd1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 3'd0, 1'b1, 16'd1};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 3'd0, 1'b0, 16'd1};
        tbl[6] = '{1'b1, 32'hC0C0_0003, 1'b1, 3'd1, 1'b1, 16'd2};
        tbl[7] = '{1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 16'd2};

        #12;
        chk("rst_spdif_rst", spdif_rst_o, 1);
        chk("rst_sample", spdif_sample_o, 0);
        chk("rst_bit_en", spdif_bit_en_o, 0);
        chk("rst_rate", rate_o, 0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_cnt", underrun_cnt_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_ready", s_ready_o, 0);
        chk("rst_running", running_o, 0);
        rst_i    = 1'b0;
        enable_i = 1'b1;
        cyc();
        chk("prime_ready", s_ready_o, 1);
        step(1'b1, 32'h1111_2222, 1'b0);
        step(1'b1, 32'h3333_4444, 1'b0);
        chk("prime_level2", fifo_level_o, 2);
        chk("prime_still_rst", spdif_rst_o, 1);
        cyc();
        last_smp = mdl.pop_front();
        chk("run_first_sample", spdif_sample_o, last_smp);
        chk("run_rst_low", spdif_rst_o, 0);
        chk("run_running", running_o, 1);
        chk("run_level1", fifo_level_o, 1);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_level", i), fifo_level_o, tbl[i].lvl);
            chk($sformatf("tbl%0d_underrun", i), underrun_o, tbl[i].und);
            chk($sformatf("tbl%0d_cnt", i), underrun_cnt_o, tbl[i].cnt);
        end

        clr_stat_i = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        clr_stat_i = 1'b0;
        chk("clr_prio_underrun", underrun_o, 1);
        chk("clr_prio_cnt", underrun_cnt_o, 0);

        for (int i = 0; i < 4; i++) step(1'b1, 32'hD000_0000 + i, 1'b0);
        chk("full_level", fifo_level_o, 4);
        chk("full_not_ready", s_ready_o, 0);
        step(1'b1, 32'hD000_0004, 1'b0);
        chk("full_hold_level", fifo_level_o, 4);
        step(1'b1, 32'hD000_0004, 1'b1);
        chk("full_pop_level", fifo_level_o, 3);
        chk("full_pop_ready", s_ready_o, 1);
        step(1'b1, 32'hD000_0004, 1'b0);
        chk("full_refill_level", fifo_level_o, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        chk("drain_level", fifo_level_o, 0);

        count_pulses(25_000, p, a);
        chk("nco48_in_range", (p >= 3071 && p <= 3073), 1);
        chk("nco48_adjacent", a, 0);

        while (nreq % 192 != 191) begin
            if (nreq >= 50) rate_sel_i = 1'b1;
            step(1'b1, 32'hE000_0000 + nreq, 1'b0);
            step(1'b0, 32'h0, 1'b1);
        end
        chk("rate_before_wrap", rate_o, 0);
        step(1'b1, 32'hE0E0_0191, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("rate_after_wrap", rate_o, 1);
        chk("rate_no_underrun", underrun_cnt_o, 0);

        count_pulses(25_000, p, a);
        chk("nco44_in_range", (p >= 2821 && p <= 2824), 1);
        chk("nco44_adjacent", a, 0);

        step(1'b1, 32'hF000_0001, 1'b0);
        step(1'b1, 32'hF000_0002, 1'b0);
        enable_i   = 1'b0;
        rate_sel_i = 1'b0;
        cyc();
        chk("dis_rst", spdif_rst_o, 1);
        chk("dis_level", fifo_level_o, 0);
        chk("dis_running", running_o, 0);
        chk("dis_sample", spdif_sample_o, 0);
        chk("dis_ready", s_ready_o, 0);
        chk("dis_bit_en", spdif_bit_en_o, 0);
        mdl.delete();
        sb.delete();
        nreq = 0;
        spdif_req_i = 1'b1;
        cyc();
        spdif_req_i = 1'b0;
        chk("idle_req_no_underrun", underrun_o, 0);
        chk("idle_req_cnt", underrun_cnt_o, 0);
        chk("idle_rate_follows", rate_o, 0);

        enable_i = 1'b1;
        cyc();
        step(1'b1, 32'h5555_6666, 1'b0);
        chk("reprime_level", fifo_level_o, 1);
        chk("reprime_rst", spdif_rst_o, 1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_level", fifo_level_o, 0);
        chk("async_ready", s_ready_o, 0);
        chk("async_rst", spdif_rst_o, 1);
        chk("async_sample", spdif_sample_o, 0);
        #10;
        rst_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
